// File: rtl/neural_layer_seq_if.sv
// Start/done handshake, operand and result bundle for neural_layer_seq.
interface neural_layer_seq_if #(
  parameter int IN_SIZE  = 10,
  parameter int OUT_SIZE = 5
);
  logic                           start;
  logic [1:0]                     activation;
  logic [32*IN_SIZE-1:0]          in;
  logic [32*IN_SIZE*OUT_SIZE-1:0] weights;
  logic [32*OUT_SIZE-1:0]         bias;
  logic                           busy;
  logic                           done;
  logic                           result_valid;
  logic [32*OUT_SIZE-1:0]         result;

  modport master (
    output start, activation, in, weights, bias,
    input  busy, done, result_valid, result
  );

  modport slave (
    input  start, activation, in, weights, bias,
    output busy, done, result_valid, result
  );
endinterface

// File: rtl/neural_layer_seq.sv
// Sequential fully-connected layer: LANES float MAC lanes time-multiplexed over
// OUT_SIZE neurons, bias-initialised accumulators, optional ReLU on write-back.
module neural_layer_seq #(
  parameter int IN_SIZE  = 10,
  parameter int OUT_SIZE = 5,
  parameter int LANES    = 1
) (
  input logic               clk,
  input logic               rst,
  neural_layer_seq_if.slave bus
);

  localparam int G  = OUT_SIZE / LANES;
  localparam int KW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(IN_SIZE - 1);
  localparam logic [GW-1:0] G_LAST = GW'(G - 1);

  if (OUT_SIZE % LANES != 0) begin : g_lanes_check
    $error("neural_layer_seq: LANES must divide OUT_SIZE");
  end

  // Single-precision multiply, round-to-nearest-even; subnormals flush to zero.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, st;
    logic [47:0] p;
    logic signed [9:0] e;
    logic [23:0] m;
    logic [31:0] r;
    s      = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hff) && (a[22:0] != '0);
    b_nan  = (b[30:23] == 8'hff) && (b[22:0] != '0);
    a_inf  = (a[30:23] == 8'hff) && (a[22:0] == '0);
    b_inf  = (b[30:23] == 8'hff) && (b[22:0] == '0);
    a_zero = (a[30:23] == '0);
    b_zero = (b[30:23] == '0);
    p = '0; e = '0; m = '0; g = 1'b0; st = 1'b0;
    if (a_nan || b_nan) r = 32'h7fc00000;
    else if (a_inf || b_inf) r = (a_zero || b_zero) ? 32'h7fc00000 : {s, 8'hff, 23'b0};
    else if (a_zero || b_zero) r = {s, 31'b0};
    else begin
      p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
      e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
      if (p[47]) begin
        m = {1'b0, p[46:24]}; g = p[23]; st = |p[22:0]; e = e + 10'sd1;
      end else begin
        m = {1'b0, p[45:23]}; g = p[22]; st = |p[21:0];
      end
      if (g && (st || m[0])) m = m + 24'd1;
      if (m[23]) e = e + 10'sd1;
      if (e >= 10'sd255)   r = {s, 8'hff, 23'b0};
      else if (e <= 10'sd0) r = {s, 31'b0};
      else                  r = {s, e[7:0], m[22:0]};
    end
    return r;
  endfunction

  // Single-precision add, round-to-nearest-even with guard/round/sticky bits.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, st, found;
    logic [31:0] big, sml, r;
    logic [26:0] mb, ms, m;
    logic [27:0] sum;
    logic [24:0] mr;
    logic [7:0]  d;
    logic [4:0]  lz;
    logic signed [9:0] e;
    a_nan  = (a[30:23] == 8'hff) && (a[22:0] != '0);
    b_nan  = (b[30:23] == 8'hff) && (b[22:0] != '0);
    a_inf  = (a[30:23] == 8'hff) && (a[22:0] == '0);
    b_inf  = (b[30:23] == 8'hff) && (b[22:0] == '0);
    a_zero = (a[30:23] == '0);
    b_zero = (b[30:23] == '0);
    big = a; sml = b; mb = '0; ms = '0; m = '0; sum = '0; mr = '0;
    d = '0; lz = '0; e = '0; st = 1'b0; found = 1'b0;
    if (a_nan || b_nan) r = 32'h7fc00000;
    else if (a_inf && b_inf) r = (a[31] != b[31]) ? 32'h7fc00000 : a;
    else if (a_inf) r = a;
    else if (b_inf) r = b;
    else if (a_zero && b_zero) r = {a[31] & b[31], 31'b0};
    else if (a_zero) r = b;
    else if (b_zero) r = a;
    else begin
      if (a[30:0] < b[30:0]) begin big = b; sml = a; end
      mb = {1'b1, big[22:0], 3'b000};
      ms = {1'b1, sml[22:0], 3'b000};
      d  = big[30:23] - sml[30:23];
      if (d >= 8'd27) ms = 27'd1;
      else begin
        st = |(ms & ((27'd1 << d) - 27'd1));
        ms = (ms >> d) | {26'b0, st};
      end
      e = $signed({2'b00, big[30:23]});
      if (big[31] == sml[31]) begin
        sum = {1'b0, mb} + {1'b0, ms};
        if (sum[27]) begin
          m = sum[27:1] | {26'b0, sum[0]}; e = e + 10'sd1;
        end else m = sum[26:0];
      end else m = mb - ms;
      if (m == '0) r = '0;
      else begin
        for (int unsigned i = 0; i < 27; i++)
          if (!found && m[26-i]) begin lz = 5'(i); found = 1'b1; end
        m = m << lz;
        e = e - $signed({5'b0, lz});
        mr = {1'b0, m[26:3]};
        if (m[2] && (m[1] || m[0] || m[3])) mr = mr + 25'd1;
        if (mr[24]) begin mr = mr >> 1; e = e + 10'sd1; end
        if (e >= 10'sd255)    r = {big[31], 8'hff, 23'b0};
        else if (e <= 10'sd0) r = {big[31], 31'b0};
        else                  r = {big[31], e[7:0], mr[22:0]};
      end
    end
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

  state_t                 state, state_n;
  logic [KW-1:0]          k;
  logic [GW-1:0]          g, g_next;
  logic [31:0]            acc [LANES];
  logic [31:0]            acc_mac [LANES];
  logic [31:0]            acc_bias [LANES];
  logic [31:0]            acc_act [LANES];
  logic                   relu;
  logic                   busy_q, done_q, valid_q;
  logic [32*OUT_SIZE-1:0] result_q;
  logic                   load, mac, wr, last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    mac     = 1'b0;
    wr      = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE:  if (bus.start) begin load = 1'b1; state_n = MAC; end
      MAC:   begin mac = 1'b1; if (k == K_LAST) state_n = WRITE; end
      WRITE: begin
        wr = 1'b1;
        if (g == G_LAST) begin last = 1'b1; state_n = IDLE; end
        else state_n = MAC;
      end
      default: state_n = IDLE;
    endcase
  end

  // Bias reload targets group 0 on start and the following group on write-back.
  assign g_next = (wr && !last) ? g + GW'(1) : '0;

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      acc_mac[l]  = fadd(acc[l], fmul(bus.in[32*k +: 32],
                    bus.weights[32*((32'(g)*LANES + l)*IN_SIZE + 32'(k)) +: 32]));
      acc_bias[l] = bus.bias[32*(32'(g_next)*LANES + l) +: 32];
      acc_act[l]  = (relu && acc[l][31]) ? 32'h00000000 : acc[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k        <= '0;
      g        <= '0;
      relu     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      for (int unsigned l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        busy_q  <= 1'b1;
        valid_q <= 1'b0;
        relu    <= (bus.activation == 2'b01);
        k       <= '0;
        g       <= '0;
        for (int unsigned l = 0; l < LANES; l++) acc[l] <= acc_bias[l];
      end
      if (mac) begin
        k <= (k == K_LAST) ? '0 : k + KW'(1);
        for (int unsigned l = 0; l < LANES; l++) acc[l] <= acc_mac[l];
      end
      if (wr) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          result_q[32*(32'(g)*LANES + l) +: 32] <= acc_act[l];
          acc[l] <= acc_bias[l];
        end
        k <= '0;
        g <= g_next;
        if (last) begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result_valid = valid_q;
  assign bus.result       = result_q;

endmodule
